// File: rtl/regfile_pkg.sv
// regfile_pkg: FSM state encoding and default geometry for the multi-port register file.
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with zero-register forcing and optional write bypass.
// Bypass wiring exists only when REGFILE_BYPASS_EN is defined.
module regfile_rdport import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic              wen0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              wen1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
`endif
  output logic [DATA_W-1:0] rdata_o,
  output logic              rbusy_o
);
  logic live;
  assign live = en_i && raddr_i != '0;
`ifdef REGFILE_BYPASS_EN
  logic hit0, hit1;
  assign hit0 = wen0_i && waddr0_i == raddr_i;
  assign hit1 = wen1_i && waddr1_i == raddr_i;
  assign rdata_o = !live ? '0 : hit1 ? wdata1_i : hit0 ? wdata0_i : mem_i[raddr_i];
  assign rbusy_o = live && !(hit0 || hit1) && busy_i[raddr_i];
`else
  assign rdata_o = live ? mem_i[raddr_i] : '0;
  assign rbusy_o = live && busy_i[raddr_i];
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with busy scoreboard and sequential clear FSM.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     wen0_i,
  input  logic [ADDR_W-1:0]        waddr0_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic                     wen1_i,
  input  logic [ADDR_W-1:0]        waddr1_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  input  logic                     clr_req_i,
  output logic                     ready_o
);
  localparam int DEPTH = 1 << ADDR_W;
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic en, act, clearing;
  assign en       = rst && state_q == READY;
  assign act      = en && !clr_req_i;
  assign clearing = rst && state_q == CLEAR;
  assign ready_o  = state_q == READY;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      busy_q[cnt_q] <= 1'b0;
      cnt_q         <= cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_q <= READY;
    end else if (clr_req_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      if (wen0_i) busy_q[waddr0_i] <= 1'b0;
      if (wen1_i) busy_q[waddr1_i] <= 1'b0;
      // issue is applied last so it wins over a same-address write
      if (iss_en_i && iss_addr_i != '0) busy_q[iss_addr_i] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (clearing) mem_q[cnt_q] <= '0;
    else if (act) begin
      if (wen0_i && waddr0_i != '0) mem_q[waddr0_i] <= wdata0_i;
      if (wen1_i && waddr1_i != '0) mem_q[waddr1_i] <= wdata1_i;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .en_i    (en),
      .raddr_i (raddr_i[k*ADDR_W +: ADDR_W]),
      .mem_i   (mem_q),
      .busy_i  (busy_q),
`ifdef REGFILE_BYPASS_EN
      .wen0_i  (act && wen0_i),
      .waddr0_i(waddr0_i),
      .wdata0_i(wdata0_i),
      .wen1_i  (act && wen1_i),
      .waddr1_i(waddr1_i),
      .wdata1_i(wdata1_i),
`endif
      .rdata_o (rdata_o[k*DATA_W +: DATA_W]),
      .rbusy_o (rbusy_o[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven, scoreboarded bench for regfile_mp (default geometry, two read ports).
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic wen0 = 1'b0, wen1 = 1'b0, iss = 1'b0, clr = 1'b0;
  logic [AW-1:0] waddr0 = '0, waddr1 = '0, iss_addr = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic ready;
  int checks = 0, failures = 0;
  typedef struct {
    logic we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic is;  logic [AW-1:0] ia;
    logic [AW-1:0] ra; logic [DW-1:0] ed; logic eb;
  } vec_t;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; logic b;} exp_t;
  vec_t vecs[10];
  exp_t sb[$];
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .iss_en_i(iss), .iss_addr_i(iss_addr), .clr_req_i(clr), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; iss = 1'b0; clr = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a);
    raddr = {a, a};
    #1;
  endtask
  task automatic chk_reg(input string nm, input logic [DW-1:0] d, input logic b);
    chk({nm, "_p0"}, rdata[0 +: DW], d);
    chk({nm, "_p1"}, rdata[DW +: DW], d);
    chk({nm, "_busy"}, DW'(rbusy), DW'({b, b}));
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      if (n == 20) begin
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hFF;
        iss = 1'b1; iss_addr = 5'd2;
      end else idle();
      tick();
      n++;
    end
    idle();
  endtask
  initial begin
    int n;
    exp_t e;
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 5'd5,  32'h11,       1'b1, 5'd5,  32'h22,       1'b0, 5'd0, 5'd5,  32'h22,       1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  32'h0,        1'b1};
    vecs[4] = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  32'h55,       1'b0};
    vecs[5] = '{1'b1, 5'd7,  32'h66,       1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  32'h66,       1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  32'h0,        1'b0};
    vecs[7] = '{1'b1, 5'd30, 32'h1,        1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0, 5'd31, 32'hCAFEF00D, 1'b0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd30, 32'h1,        1'b0};
    vecs[9] = '{1'b1, 5'd5,  32'h33,       1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 5'd6,  32'h0,        1'b1};
    repeat (3) tick();
    chk("rst_ready", DW'(ready), 32'h0);
    rd(5'd3);
    chk_reg("rst_read", 32'h0, 1'b0);
    rst = 1'b1;
    wait_ready(n);
    chk("init_clear_cycles", DW'(n), 32'd32);
    rd(5'd2);
    chk_reg("init_read", 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wen0 = vecs[i].we0; waddr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      wen1 = vecs[i].we1; waddr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      iss = vecs[i].is;   iss_addr = vecs[i].ia;
      sb.push_back('{vecs[i].ra, vecs[i].ed, vecs[i].eb});
      tick();
      idle();
      e = sb.pop_front();
      rd(e.a);
      chk_reg($sformatf("vec%0d", i), e.d, e.b);
    end
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    tick();
    idle();
    iss = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5;
    rd(5'd9);
`ifdef REGFILE_BYPASS_EN
    chk_reg("same_cycle_read", 32'hA5A5, 1'b0);
`else
    chk_reg("same_cycle_read", 32'h77, 1'b1);
`endif
    tick();
    idle();
    rd(5'd9);
    chk_reg("after_write", 32'hA5A5, 1'b0);
    wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h99;
    clr = 1'b1;
    tick();
    idle();
    chk("clr_ready", DW'(ready), 32'h0);
    rd(5'd5);
    chk_reg("clr_read", 32'h0, 1'b0);
    repeat (9) tick();
    rst = 1'b0;
    tick();
    chk("midclr_rst_ready", DW'(ready), 32'h0);
    rst = 1'b1;
    wait_ready(n);
    chk("restart_clear_cycles", DW'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a));
      chk_reg($sformatf("cleared_x%0d", a), 32'h0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 raddr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 rdata_o  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 rbusy_o  out  NUM_RD  pending-write flag of the register addressed by port k.
REQ-009 wen0_i/waddr0_i/wdata0_i  in  1/ADDR_W/DATA_W  write port 0.
REQ-010 wen1_i/waddr1_i/wdata1_i  in  1/ADDR_W/DATA_W  write port 1, priority over port 0.
REQ-011 iss_en_i/iss_addr_i  in  1/ADDR_W  issue: mark destination register busy.
REQ-012 clr_req_i  in  1  single-cycle request to re-clear the whole array.
REQ-013 ready_o  out  1  high when array is cleared and accepting writes/issues.

Function
REQ-014 Block SHALL have an FSM with states CLEAR and READY; reset value CLEAR, clear counter 0.
REQ-015 In CLEAR, one register per cycle SHALL be zeroed and its busy bit cleared, counter incrementing 0..DEPTH-1; after counter DEPTH-1 the FSM SHALL enter READY (clear takes DEPTH cycles).
REQ-016 In CLEAR, ready_o=0, rdata_o=0, rbusy_o=0, and writes and issues SHALL be ignored.
REQ-017 In READY, clr_req_i=1 SHALL move FSM to CLEAR with counter 0 on the next edge; writes in that cycle are discarded.
REQ-018 Register 0 SHALL always read 0, never be written, and never be busy.
REQ-019 Reads SHALL be combinational (zero latency) on every port independently.
REQ-020 Write SHALL update the array on the rising edge; wen with address 0 is a no-op.
REQ-021 wen0 and wen1 to the same address in one cycle: wdata1 SHALL be stored.
REQ-022 iss_en_i SHALL set the busy bit of iss_addr_i at the edge; a write SHALL clear the busy bit of its address.
REQ-023 Issue and write to the same address in one cycle: busy SHALL end set (issue wins), data SHALL be written.
REQ-024 rbusy_o[k] SHALL reflect the registered busy bit of raddr k (no bypass of issue/clear in the same cycle).

Reset
REQ-025 rst=0 at a clock edge SHALL force CLEAR, counter 0, ready_o=0; rdata_o and rbusy_o SHALL be 0 combinationally while rst=0.
REQ-026 Reset asserted mid-clear SHALL restart clearing from address 0.
REQ-027 Array contents are not reset directly; they are zeroed only by the CLEAR sequence.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: in READY, a read whose address matches an active write this cycle SHALL return the write data (port 1 over port 0) and rbusy_o=0 for that port.
REQ-029 REGFILE_BYPASS_EN undefined: reads SHALL return the stored (pre-write) value and the registered busy bit.

Structure
REQ-030 Shared package regfile_pkg SHALL hold FSM state encoding (CLEAR, READY) and default DATA_W/ADDR_W constants.
REQ-031 Sub-module regfile_rdport (one read port: address decode, zero-register and bypass mux) SHALL be instantiated NUM_RD times by generate.

Verification
REQ-032 Reset release, ADDR_W=5 -> ready_o=0 for exactly 32 cycles, then 1; all reads 0.
REQ-033 Write x3=0xDEADBEEF, next cycle read port 1 addr 3 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-034 wen0 x5=0x11 and wen1 x5=0x22 same cycle -> x5 reads 0x22.
REQ-035 iss x7 -> rbusy=1 next cycle; write x7=0x55 -> rbusy=0; same-cycle iss+write x7 -> rbusy=1, data 0x55.
REQ-036 With REGFILE_BYPASS_EN, write x9=0xA5A5 and read x9 same cycle -> 0xA5A5; without -> previous value.
REQ-037 clr_req_i after populating registers, then rst low at clear cycle 10 -> clear restarts, after 32 cycles all registers 0, busy 0.
